// File: rtl/crypt_wb_buffer.sv
// rtl/crypt_wb_buffer.sv - in-order writeback queue between crypt engine and MPRF with hazard forwarding
module crypt_wb_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crypt2wb_req,
  input  logic [4:0]  crypt2wb_rd_addr,
  input  logic [31:0] crypt2wb_rd_data,
  output logic        wb2crypt_rdy,
  output logic        wb2mprf_wreq,
  output logic [4:0]  wb2mprf_rd_addr,
  output logic [31:0] wb2mprf_rd_data,
  input  logic        mprf2wb_gnt,
  input  logic [4:0]  idu2wb_rs1_addr,
  input  logic [4:0]  idu2wb_rs2_addr,
  output logic        wb2idu_rs1_hit,
  output logic        wb2idu_rs2_hit,
  output logic [31:0] wb2idu_rs1_fwd,
  output logic [31:0] wb2idu_rs2_fwd,
  output logic        wb2idu_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic [32:0]      rs1_lkp, rs2_lkp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Walk entries oldest to youngest so the last match left in r is the youngest one.
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic [32:0] r;
    logic [PW:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rd_ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(DEPTH)) idx = idx - (PW+1)'(DEPTH);
      if (valid_q[idx[PW-1:0]] && (addr_q[idx[PW-1:0]] == rs) && (rs != 5'd0))
        r = {1'b1, data_q[idx[PW-1:0]]};
    end
    return r;
  endfunction

  // Ready depends only on occupancy so the crypt engine never sees a grant-to-ready path.
  assign wb2crypt_rdy    = (count_q != CW'(DEPTH));
  assign wb2mprf_wreq    = (count_q != '0);
  assign wb2idu_empty    = (count_q == '0);
  assign push            = crypt2wb_req & wb2crypt_rdy & (crypt2wb_rd_addr != 5'd0);
  assign pop             = wb2mprf_wreq & mprf2wb_gnt;
  assign wb2mprf_rd_addr = wb2mprf_wreq ? addr_q[rd_ptr_q] : '0;
  assign wb2mprf_rd_data = wb2mprf_wreq ? data_q[rd_ptr_q] : '0;

  // Hazard lookup sees only current state; a result being pushed shows up next cycle.
  always_comb begin
    rs1_lkp = lookup(idu2wb_rs1_addr);
    rs2_lkp = lookup(idu2wb_rs2_addr);
  end

  assign wb2idu_rs1_hit = rs1_lkp[32];
  assign wb2idu_rs1_fwd = rs1_lkp[31:0];
  assign wb2idu_rs2_hit = rs2_lkp[32];
  assign wb2idu_rs2_fwd = rs2_lkp[31:0];

  // Pointer and occupancy next state; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Queue storage; reset discards every pending entry without writing it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop)
        valid_q[rd_ptr_q] <= 1'b0;
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        addr_q[wr_ptr_q]  <= crypt2wb_rd_addr;
        data_q[wr_ptr_q]  <= crypt2wb_rd_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A request presented while full is dropped; flag it as an upstream protocol error.
  req_while_full_a: assert property (@(posedge clk) disable iff (rst)
    !(crypt2wb_req && !wb2crypt_rdy));

endmodule

// File: tb/tb_crypt_wb_buffer.sv
// tb/tb_crypt_wb_buffer.sv - directed bench with queue model for crypt_wb_buffer
`timescale 1ns/1ps
module tb_crypt_wb_buffer;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, gnt;
  logic [4:0]  rd_addr, rs1, rs2;
  logic [31:0] rd_data;
  logic        rdy, wreq, hit1, hit2, empty;
  logic [4:0]  waddr;
  logic [31:0] wdata, fwd1, fwd2;

  crypt_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .crypt2wb_req(req), .crypt2wb_rd_addr(rd_addr), .crypt2wb_rd_data(rd_data),
    .wb2crypt_rdy(rdy),
    .wb2mprf_wreq(wreq), .wb2mprf_rd_addr(waddr), .wb2mprf_rd_data(wdata),
    .mprf2wb_gnt(gnt),
    .idu2wb_rs1_addr(rs1), .idu2wb_rs2_addr(rs2),
    .wb2idu_rs1_hit(hit1), .wb2idu_rs2_hit(hit2),
    .wb2idu_rs1_fwd(fwd1), .wb2idu_rs2_fwd(fwd2),
    .wb2idu_empty(empty)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  logic [36:0] mq[$];
  logic [4:0]  obs_a[$];
  logic [31:0] obs_d[$];
  logic [32:0] f1, f2;
  bit          m_pop, m_push;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] rs);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (rs != 5'd0 && mq[i][36:32] == rs) return {1'b1, mq[i][31:0]};
    return 33'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() != 0) && gnt;
      m_push = req && (mq.size() < DEPTH) && (rd_addr != 5'd0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({rd_addr, rd_data});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      f1 = model_fwd(rs1);
      f2 = model_fwd(rs2);
      check("rdy",   32'(rdy),   32'(mq.size() < DEPTH));
      check("wreq",  32'(wreq),  32'(mq.size() != 0));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("waddr", 32'(waddr), (mq.size() != 0) ? 32'(mq[0][36:32]) : 32'd0);
      check("wdata", wdata,      (mq.size() != 0) ? mq[0][31:0] : 32'd0);
      check("hit1",  32'(hit1),  32'(f1[32]));
      check("fwd1",  fwd1,       f1[31:0]);
      check("hit2",  32'(hit2),  32'(f2[32]));
      check("fwd2",  fwd2,       f2[31:0]);
      if (wreq && gnt && !rst) begin
        obs_a.push_back(waddr);
        obs_d.push_back(wdata);
      end
    end
  end

  task automatic drive(input logic r, input logic [4:0] a, input logic [31:0] d, input logic g);
    req = r; rd_addr = a; rd_data = d; gnt = g;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    obs_a.delete();
    obs_d.delete();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rd_addr = '0; rd_data = '0; gnt = 1'b0; rs1 = '0; rs2 = '0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b0;
    started = 1'b1;
    check("rst_rdy",   32'(rdy),   32'd1);
    check("rst_wreq",  32'(wreq),  32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata,      32'd0);

    // reset with a pending entry
    clear_obs();
    drive(1'b1, 5'd5, 32'h11111111, 1'b0);
    check("t1_wreq", 32'(wreq),  32'd1);
    check("t1_addr", 32'(waddr), 32'd5);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b0;
    check("t1_wreq_rst",  32'(wreq),  32'd0);
    check("t1_empty_rst", 32'(empty), 32'd1);
    check("t1_rdy_rst",   32'(rdy),   32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t1_no_write", obs_a.size(), 32'd0);

    // single pass-through with grant held
    clear_obs();
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
    check("t2_wreq", 32'(wreq),  32'd1);
    check("t2_addr", 32'(waddr), 32'd3);
    check("t2_data", wdata,      32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t2_wreq_after", 32'(wreq),  32'd0);
    check("t2_empty",      32'(empty), 32'd1);
    check("t2_nwr", obs_a.size(), 32'd1);
    if (obs_a.size() == 1) begin
      check("t2_wr_addr", 32'(obs_a[0]), 32'd3);
      check("t2_wr_data", obs_d[0],      32'hDEADBEEF);
    end

    // backpressure to full, then drain
    clear_obs();
    rs2 = 5'd2;
    drive(1'b1, 5'd1, 32'hA, 1'b0);
    check("t3_rdy1", 32'(rdy), 32'd1);
    drive(1'b1, 5'd2, 32'hB, 1'b0);
    check("t3_rdy_full", 32'(rdy),   32'd0);
    check("t3_head",     32'(waddr), 32'd1);
    check("t3_hit2",     32'(hit2),  32'd1);
    check("t3_fwd2",     fwd2,       32'hB);
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("t3_hold_addr", 32'(waddr), 32'd1);
    check("t3_hold_data", wdata,      32'hA);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t3_rdy_back", 32'(rdy),   32'd1);
    check("t3_head2",    32'(waddr), 32'd2);
    check("t3_data2",    wdata,      32'hB);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_nwr", obs_a.size(), 32'd2);
    if (obs_a.size() == 2) begin
      check("t3_wr0", {obs_a[0], obs_d[0][26:0]}, {5'd1, 27'hA});
      check("t3_wr1", {obs_a[1], obs_d[1][26:0]}, {5'd2, 27'hB});
    end
    rs2 = 5'd0;

    // same-rd forwarding picks the youngest
    clear_obs();
    rs1 = 5'd7;
    drive(1'b1, 5'd7, 32'h1, 1'b0);
    check("t4_hit_a", 32'(hit1), 32'd1);
    check("t4_fwd_a", fwd1,      32'h1);
    drive(1'b1, 5'd7, 32'h2, 1'b0);
    check("t4_hit_b", 32'(hit1), 32'd1);
    check("t4_fwd_b", fwd1,      32'h2);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t4_fwd_pop", fwd1,  32'h2);
    check("t4_head",    wdata, 32'h2);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t4_hit_end", 32'(hit1), 32'd0);
    check("t4_fwd_end", fwd1,      32'd0);
    check("t4_nwr", obs_a.size(), 32'd2);
    if (obs_a.size() == 2) begin
      check("t4_wr0", obs_d[0], 32'h1);
      check("t4_wr1", obs_d[1], 32'h2);
    end

    // x0 destination is consumed silently
    rs1 = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    check("t5_rdy",   32'(rdy),   32'd1);
    check("t5_wreq",  32'(wreq),  32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_hit1",  32'(hit1),  32'd0);

    // push and pop together at count 1, wrapping both pointers
    clear_obs();
    rs1 = 5'd12;
    drive(1'b1, 5'd10, 32'h100, 1'b1);
    check("t6_first", 32'(waddr), 32'd10);
    for (int k = 1; k <= 2 * DEPTH + 1; k++) begin
      drive(1'b1, 5'(10 + k), 32'h100 + 32'(k), 1'b1);
      check("t6_head",  32'(waddr), 32'(10 + k));
      check("t6_data",  wdata,      32'h100 + 32'(k));
      check("t6_cnt1",  32'({rdy, empty}), 32'b10);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_nwr", obs_a.size(), 32'(2 * DEPTH + 2));
    if (obs_a.size() == 2 * DEPTH + 2) begin
      for (int k = 0; k < 2 * DEPTH + 2; k++) begin
        check("t6_wr_addr", 32'(obs_a[k]), 32'(10 + k));
        check("t6_wr_data", obs_d[k],      32'h100 + 32'(k));
      end
    end

    drive(1'b0, 5'd0, 32'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crypt_wb_buffer.md
Name: crypt_wb_buffer

Overview:
- Writeback stage directly downstream of the crypt engine.
- Captures each crypt result (rd address plus 32-bit data) into a small in-order queue.
- Drains the queue into the MPRF write port when the port arbiter grants access.
- Reports pending-write hazards to the IDU and forwards the youngest matching pending result, so dependent crypt/ALU ops can issue without waiting for the MPRF write.

Parameters:
DEPTH, 2, number of pending-write entries (legal 2..4)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
crypt2wb_req  in  1  crypt result valid this cycle
crypt2wb_rd_addr  in  5  destination register of the result
crypt2wb_rd_data  in  32  result data
wb2crypt_rdy  out  1  buffer can accept a result this cycle
wb2mprf_wreq  out  1  write request to the MPRF crypt write port
wb2mprf_rd_addr  out  5  write address, head entry
wb2mprf_rd_data  out  32  write data, head entry
mprf2wb_gnt  in  1  write port granted this cycle
idu2wb_rs1_addr  in  5  source 1 address of the instruction in decode
idu2wb_rs2_addr  in  5  source 2 address of the instruction in decode
wb2idu_rs1_hit  out  1  rs1 matches a pending entry
wb2idu_rs2_hit  out  1  rs2 matches a pending entry
wb2idu_rs1_fwd  out  32  data of the youngest pending entry matching rs1
wb2idu_rs2_fwd  out  32  data of the youngest pending entry matching rs2
wb2idu_empty  out  1  no pending entries

Behaviour:
- Storage:
  - Circular queue of DEPTH entries {valid, rd_addr[4:0], data[31:0]}.
  - Write pointer, read pointer and count (width clog2(DEPTH)+1); pointers wrap DEPTH-1 -> 0.
- Reset: count=0, both pointers=0, all valid=0. All outputs read 0 except wb2crypt_rdy=1 and wb2idu_empty=1.
- Accept:
  - wb2crypt_rdy = (count != DEPTH). It is purely registered state and never depends on mprf2wb_gnt.
  - Push when crypt2wb_req & wb2crypt_rdy & (crypt2wb_rd_addr != 0).
  - A request with rd_addr=0 is consumed, never enqueued, and never raises wreq.
  - A request while !rdy is a protocol violation; the buffer ignores it, state is unchanged, and an assertion fires.
- Drain:
  - wb2mprf_wreq = (count != 0). addr/data = head entry while wreq=1, otherwise 0.
  - Pop when wreq & mprf2wb_gnt.
  - The head holds stable until granted; gnt with wreq=0 is ignored.
- Latency: a result pushed in cycle N is presented on the MPRF port in cycle N+1 at the earliest. Minimum result-to-register-file latency is 1 cycle plus grant wait.
- Simultaneous push and pop: both occur, count unchanged. When full, a push in the same cycle as a pop is still refused, because rdy was already 0.
- Ordering: strictly in-order. Two pending writes to the same rd are both written, oldest first.
- Hazard and forwarding (combinational from current state):
  - rsX_hit = OR over valid entries of (entry.rd_addr == rsX_addr) & (rsX_addr != 0).
  - rsX_fwd = data of the youngest matching valid entry, or 0 if there is no hit.
  - An entry popped this cycle still counts as a hit this cycle.
  - A result being pushed this cycle is not visible until the next cycle.
- wb2idu_empty = (count == 0).
- Reset mid-operation: all pending entries are discarded with no MPRF write. Outputs return to reset values in the cycle after rst is sampled high.

Test Plan:
- Reset with pending entries: push x5=0x11111111, assert rst next cycle -> wreq=0, empty=1, rdy=1; no MPRF write of x5 ever occurs.
- Single pass-through with gnt tied 1: push x3=0xDEADBEEF in cycle 0 -> wreq=1, addr=3, data=0xDEADBEEF in cycle 1 only; empty=1 in cycle 2.
- Backpressure to full (DEPTH=2, gnt=0): push x1=0xA, x2=0xB -> rdy=0 after the second push. Raise gnt -> writes x1=0xA then x2=0xB in consecutive cycles; rdy returns to 1 the cycle after the first pop.
- Same-rd forwarding: gnt=0, push x7=0x1 then x7=0x2, rs1=7 -> rs1_hit=1, rs1_fwd=0x2. After the first pop, rs1_fwd is still 0x2 and the MPRF sees 0x1 then 0x2.
- x0 discard: push rd=0, data=0xFFFFFFFF -> rdy stays 1, wreq stays 0; rs1=0 gives rs1_hit=0.
- Push and pop in the same cycle with count=1: count stays 1, the new entry becomes head next cycle, and wrap-around of both pointers is exercised over 2*DEPTH+1 transfers with correct data order.
